// File: rtl/temp_disp_pkg.sv
// Shared constants and types for the temperature display path.
// Holds the active-low seven-segment codes (bit0=a .. bit6=g), the converter
// state encoding and the number of BCD digits produced.
package temp_disp_pkg;

  localparam int unsigned BCD_DIGITS = 3;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Ports:
//   i_bcd : 4-bit BCD digit
//   o_seg : segment pattern, bit0=a .. bit6=g; codes 10..15 give all segments off
module bcd_to_seg7
  import temp_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/temp_bcd_seg_encoder.sv
// Binary (0..MAX_VAL) to three-digit seven-segment encoder for the display mux.
// Sequential double-dabble, one input bit per clock; results are registered
// and only change in UPDATE or on reset.
// Optional macro LEADING_BLANK_EN: blank leading zero hundreds/tens digits.
// Ports:
//   clk100mhz : system clock
//   reset     : synchronous active-high reset
//   start     : convert request, ignored while busy
//   valor     : binary value, sampled when start is accepted
//   unidades7 / decenas7 / centenas7 : active-low segment patterns
//   busy      : conversion in progress
//   done      : one-cycle pulse when new patterns are valid
//   ovf       : last converted value exceeded MAX_VAL
module temp_bcd_seg_encoder
  import temp_disp_pkg::*;
#(
  parameter int unsigned IN_W    = 10,
  parameter int unsigned MAX_VAL = 999
) (
  input  logic            clk100mhz,
  input  logic            reset,
  input  logic            start,
  input  logic [IN_W-1:0] valor,
  output logic [6:0]      unidades7,
  output logic [6:0]      decenas7,
  output logic [6:0]      centenas7,
  output logic            busy,
  output logic            done,
  output logic            ovf
);

  localparam int unsigned CNT_W = $clog2(IN_W + 1);
  localparam int unsigned BCD_W = 4 * BCD_DIGITS;

  state_t r_state;
  state_t w_state_next;

  logic [IN_W-1:0]       r_bin;
  logic [BCD_W-1:0]      r_bcd;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf_next;
  logic [6:0]            r_unid, r_dec, r_cent;
  logic                  r_ovf;
  logic                  r_done;

  logic [BCD_W-1:0]      w_adj;
  logic [BCD_W+IN_W-1:0] w_cat;
  logic                  w_shift_last;
  logic [6:0]            w_dig_seg [BCD_DIGITS];
  logic [6:0]            w_unid, w_dec, w_cent;

  // State register
  always_ff @(posedge clk100mhz) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  assign w_shift_last = (r_cnt == CNT_W'(IN_W - 1));

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SHIFT;
      SHIFT:   if (w_shift_last) w_state_next = UPDATE;
      UPDATE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Add-3 correction on every nibble before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Carry out of the hundreds nibble falls off the top of the shift.
  assign w_cat = {w_adj, r_bin} << 1;

  for (genvar g = 0; g < int'(BCD_DIGITS); g++) begin : g_dec
    bcd_to_seg7 u_dec (
      .i_bcd(r_bcd[4*g +: 4]),
      .o_seg(w_dig_seg[g])
    );
  end

  // Select what UPDATE will latch: dashes on overflow, optional leading blanks.
  always_comb begin
    w_unid = w_dig_seg[0];
    w_dec  = w_dig_seg[1];
    w_cent = w_dig_seg[2];
`ifdef LEADING_BLANK_EN
    if (r_bcd[11:8] == 4'd0) begin
      w_cent = SEG_BLANK;
      if (r_bcd[7:4] == 4'd0) w_dec = SEG_BLANK;
    end
`endif
    if (r_ovf_next) begin
      w_unid = SEG_DASH;
      w_dec  = SEG_DASH;
      w_cent = SEG_DASH;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk100mhz) begin
    if (reset) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_next <= 1'b0;
      r_unid     <= SEG_0;
      r_dec      <= SEG_0;
      r_cent     <= SEG_0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin      <= valor;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_next <= (32'(valor) > MAX_VAL);
          end
        end
        SHIFT: begin
          r_bcd <= w_cat[IN_W +: BCD_W];
          r_bin <= w_cat[IN_W-1:0];
          r_cnt <= r_cnt + 1'b1;
        end
        UPDATE: begin
          r_unid <= w_unid;
          r_dec  <= w_dec;
          r_cent <= w_cent;
          r_ovf  <= r_ovf_next;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy      = (r_state != IDLE);
    done      = r_done;
    ovf       = r_ovf;
    unidades7 = r_unid;
    decenas7  = r_dec;
    centenas7 = r_cent;
  end

endmodule

// File: tb/tb_temp_bcd_seg_encoder.sv
// Self-checking bench for temp_bcd_seg_encoder: an arithmetic reference model
// compared every cycle, plus directed literal expectations.
module tb_temp_bcd_seg_encoder;

  localparam int IN_W = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] valor = '0;
  logic [6:0] unidades7, decenas7, centenas7;
  logic       busy, done, ovf;

  always #5 clk = ~clk;

  temp_bcd_seg_encoder dut (
    .clk100mhz(clk),
    .reset    (reset),
    .start    (start),
    .valor    (valor),
    .unidades7(unidades7),
    .decenas7 (decenas7),
    .centenas7(centenas7),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: a conversion occupies IN_W+1 edges after acceptance.
  int         m_cnt = 0;
  int         m_val = 0;
  bit         m_valid = 0;
  logic [6:0] m_u, m_t, m_h;
  logic       m_ovf, m_done;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0; m_done = 0; m_ovf = 0;
      m_u = 7'b1000000; m_t = 7'b1000000; m_h = 7'b1000000;
      m_valid = 1;
    end else begin
      m_done = 0;
      if (m_cnt == 0) begin
        if (start) begin
          m_val = int'(valor);
          m_cnt = IN_W + 1;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1;
          if (m_val > 999) begin
            m_u = 7'b0111111; m_t = 7'b0111111; m_h = 7'b0111111; m_ovf = 1;
          end else begin
            m_ovf = 0;
            m_u = seg_of(m_val % 10);
            m_t = seg_of((m_val / 10) % 10);
            m_h = seg_of(m_val / 100);
`ifdef LEADING_BLANK_EN
            if (m_val < 100) m_h = 7'b1111111;
            if (m_val < 10)  m_t = 7'b1111111;
`endif
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("unidades7", unidades7, m_u);
      chk("decenas7", decenas7, m_t);
      chk("centenas7", centenas7, m_h);
      chk("busy", busy, m_cnt != 0);
      chk("done", done, m_done);
      chk("ovf", ovf, m_ovf);
    end
  end

  always @(posedge clk) begin
    #1;
    if (done) n_done++;
  end

  // Pulse start at the current negedge, then count edges until done.
  task automatic kick(input int v, output int lat);
    start = 1'b1;
    valor = 10'(v);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input int v, output int lat);
    @(negedge clk);
    kick(v, lat);
  endtask

  task automatic chk_segs(input string name, input logic [6:0] h, input logic [6:0] t,
                          input logic [6:0] u);
    chk({name, "_cent"}, centenas7, h);
    chk({name, "_dec"}, decenas7, t);
    chk({name, "_unid"}, unidades7, u);
  endtask

  initial begin
    int lat;
    int d0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_segs("reset", 7'b1000000, 7'b1000000, 7'b1000000);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ovf", ovf, 0);
    reset = 1'b0;

    run(235, lat);
    chk("lat_235", lat, 11);
    chk_segs("v235", 7'b0100100, 7'b0110000, 7'b0010010);
    chk("ovf_235", ovf, 0);

    run(999, lat);
    chk("lat_999", lat, 11);
    chk_segs("v999", 7'b0010000, 7'b0010000, 7'b0010000);
    run(1000, lat);
    chk_segs("v1000", 7'b0111111, 7'b0111111, 7'b0111111);
    chk("ovf_1000", ovf, 1);
    run(0, lat);
    chk("ovf_cleared", ovf, 0);
`ifdef LEADING_BLANK_EN
    chk_segs("v0", 7'b1111111, 7'b1111111, 7'b1000000);
`else
    chk_segs("v0", 7'b1000000, 7'b1000000, 7'b1000000);
`endif

    // Second start during a conversion must be ignored.
    d0 = n_done;
    @(negedge clk);
    start = 1'b1;
    valor = 10'd512;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    valor = 10'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    chk("ignored_start_done_cnt", n_done - d0, 1);
    chk_segs("v512", 7'b0010010, 7'b1111001, 7'b0100100);

    // Back-to-back: start accepted on the cycle done is high.
    run(123, lat);
    chk("lat_123", lat, 11);
    kick(45, lat);
    chk("lat_b2b", lat, 11);
`ifdef LEADING_BLANK_EN
    chk_segs("v45", 7'b1111111, 7'b0011001, 7'b0010010);
`else
    chk_segs("v45", 7'b1000000, 7'b0011001, 7'b0010010);
`endif

    // Reset mid-conversion aborts with no done pulse.
    d0 = n_done;
    @(negedge clk);
    start = 1'b1;
    valor = 10'd888;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_segs("abort", 7'b1000000, 7'b1000000, 7'b1000000);
    chk("abort_busy", busy, 0);
    repeat (15) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);

    run(7, lat);
`ifdef LEADING_BLANK_EN
    chk_segs("v7", 7'b1111111, 7'b1111111, 7'b1111000);
    run(40, lat);
    chk_segs("v40", 7'b1111111, 7'b0011001, 7'b1000000);
`else
    chk_segs("v7", 7'b1000000, 7'b1000000, 7'b1111000);
    run(40, lat);
    chk_segs("v40", 7'b1000000, 7'b0011001, 7'b1000000);
`endif
    chk("lat_40", lat, 11);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
